// File: rtl/serial_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
// Shared types and helpers for the bit-serial unsigned subtractor.
//   state_t   : controller state encoding (IDLE, RUN, DONE), 2 bits
//   cnt_width : width of the bit counter, wide enough to hold WIDTH itself
// Optional build macro used by the slice: SERIAL_SUB_SIGNED_OVF_EN.
// ---------------------------------------------------------------------------
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must represent 0..WIDTH without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
// Request/result bundle for serial_subtractor.
//   start, x, y        : request side (driven by master)
//   busy, done, diff,
//   borrow [, ovf]     : result side (driven by slave)
// ovf exists only when SERIAL_SUB_SIGNED_OVF_EN is defined.
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             ovf;

    modport master (output start, x, y, input busy, done, diff, borrow, ovf);
    modport slave  (input start, x, y, output busy, done, diff, borrow, ovf);
`else
    modport master (output start, x, y, input busy, done, diff, borrow);
    modport slave  (input start, x, y, output busy, done, diff, borrow);
`endif
endinterface

// File: rtl/serial_subtractor_cell.sv
// ---------------------------------------------------------------------------
// full_subtractor_cell
// Combinational 1-bit full subtractor: a - b - bin.
//   a, b, bin : minuend bit, subtrahend bit, borrow in
//   d, bout   : difference bit, borrow out
// ---------------------------------------------------------------------------
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor, LSB first: diff = x - y over WIDTH cycles
// using a single full-subtractor cell and a borrow flip-flop.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   sif  : slave side of serial_subtractor_if (start/x/y in,
//          busy/done/diff/borrow[/ovf] out)
// Build option: define SERIAL_SUB_SIGNED_OVF_EN to add the two's-complement
// overflow flag sif.ovf.
// ---------------------------------------------------------------------------
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave sif
);
    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    // Upper WIDTH-1 bits of the working difference; the bit that would fall
    // off the LSB end is never needed again.
    logic [WIDTH-2:0] work_r;
    logic [WIDTH-1:0] work_full_s;
    logic [CW-1:0]    cnt_r;
    logic             bin_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic             busy_r;
    logic             done_r;
    logic             accept_s;
    logic             last_bit_s;
    logic             d_s;
    logic             bout_s;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             x_msb_r;
    logic             y_msb_r;
    logic             ovf_r;
`endif

    full_subtractor_cell u_cell (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .bin  (bin_r),
        .d    (d_s),
        .bout (bout_s)
    );

    // Start is only honoured when no operation is running.
    assign accept_s    = sif.start && (state_r != RUN);
    assign last_bit_s  = (cnt_r == LAST_BIT);
    assign work_full_s = {d_s, work_r};

    // Next-state decode for the IDLE/RUN/DONE controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (sif.start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_bit_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (sif.start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Controller state register plus registered busy/done flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == RUN);
            done_r  <= (state_next_s == DONE);
        end
    end

    // Operand capture, serial datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            work_r   <= '0;
            cnt_r    <= '0;
            bin_r    <= 1'b0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            x_msb_r  <= 1'b0;
            y_msb_r  <= 1'b0;
            ovf_r    <= 1'b0;
`endif
        end else if (accept_s) begin
            a_r      <= sif.x;
            b_r      <= sif.y;
            cnt_r    <= '0;
            bin_r    <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            // Operand MSBs are shifted out during RUN, so keep a copy.
            x_msb_r  <= sif.x[WIDTH-1];
            y_msb_r  <= sif.y[WIDTH-1];
`endif
        end else if (state_r == RUN) begin
            a_r    <= a_r >> 1;
            b_r    <= b_r >> 1;
            work_r <= work_full_s[WIDTH-1:1];
            bin_r  <= bout_s;
            cnt_r  <= cnt_r + CW'(1);
            // Results become visible only as a complete word.
            if (last_bit_s) begin
                diff_r   <= work_full_s;
                borrow_r <= bout_s;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                // d_s is the MSB of the final difference on this cycle.
                ovf_r    <= (x_msb_r != y_msb_r) && (d_s != x_msb_r);
`endif
            end
        end
    end

    assign sif.busy   = busy_r;
    assign sif.done   = done_r;
    assign sif.diff   = diff_r;
    assign sif.borrow = borrow_r;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    assign sif.ovf    = ovf_r;
`endif

endmodule
